// File: rtl/serial_add_arbiter.sv
// Round-robin front end for a single bit-serial full-adder cell shared by two
// requesters; each accepted operation is summed LSB-first over WIDTH cycles.
module serial_add_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Two half adders feeding an OR: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic half_s;
        half_s   = a ^ b;
        full_add = {(a & b) | (c & half_s), half_s ^ c};
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  sum_r;
    logic              carry_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              last_served_r;
    logic              res_id_r;
    logic              res_cout_r;
    logic              res_valid_r;

    logic              grant_s;
    logic              accept_s;
    logic              last_bit_s;
    logic [1:0]        fa_s;

    assign fa_s       = full_add(a_r[0], b_r[0], carry_r);
    assign last_bit_s = (state_r == RUN) && (cnt_r == CNT_LAST);
    assign accept_s   = (state_r == IDLE) && (req0_valid || req1_valid);

    // Grant selection: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_served_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign req0_ready = accept_s && !grant_s;
    assign req1_ready = accept_s && grant_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_bit_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand load, bit-serial add sequencing and result holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r           <= '0;
            b_r           <= '0;
            sum_r         <= '0;
            carry_r       <= 1'b0;
            cnt_r         <= '0;
            last_served_r <= 1'b1;
            res_id_r      <= 1'b0;
            res_cout_r    <= 1'b0;
            res_valid_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r           <= grant_s ? req1_a : req0_a;
                        b_r           <= grant_s ? req1_b : req0_b;
                        carry_r       <= 1'b0;
                        cnt_r         <= '0;
                        res_id_r      <= grant_s;
                        last_served_r <= grant_s;
                    end
                end
                RUN: begin
                    a_r     <= a_r >> 1;
                    b_r     <= b_r >> 1;
                    sum_r   <= {fa_s[0], sum_r[WIDTH-1:1]};
                    carry_r <= fa_s[1];
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (last_bit_s) begin
                        res_cout_r  <= fa_s[1];
                        res_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                    end
                end
                default: res_valid_r <= 1'b0;
            endcase
        end
    end

    assign res_valid = res_valid_r;
    assign res_id    = res_id_r;
    assign res_sum   = sum_r;
    assign res_cout  = res_cout_r;
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Scoreboard bench for serial_add_arbiter: an 8-bit instance for directed
// scenarios and a 4-bit instance for the exhaustive operand sweep.
module tb_serial_add_arbiter;

    typedef struct packed {
        logic       id;
        logic       cout;
        logic [7:0] sum;
    } res8_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       d8_r0v = 1'b0, d8_r0r, d8_r1v = 1'b0, d8_r1r;
    logic [7:0] d8_r0a = 8'h00, d8_r0b = 8'h00, d8_r1a = 8'h00, d8_r1b = 8'h00;
    logic       d8_rv, d8_rr = 1'b0, d8_rid, d8_rcout, d8_busy;
    logic [7:0] d8_rsum;

    logic       d4_r0v = 1'b0, d4_r0r, d4_r1v = 1'b0, d4_r1r;
    logic [3:0] d4_r0a = 4'h0, d4_r0b = 4'h0, d4_r1a = 4'h0, d4_r1b = 4'h0;
    logic       d4_rv, d4_rr = 1'b0, d4_rid, d4_rcout, d4_busy;
    logic [3:0] d4_rsum;

    int chk_cnt = 0;
    int pass_cnt = 0;

    res8_t      sb8[$];
    logic [5:0] sb4[$];

    serial_add_arbiter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(d8_r0v), .req0_ready(d8_r0r), .req0_a(d8_r0a), .req0_b(d8_r0b),
        .req1_valid(d8_r1v), .req1_ready(d8_r1r), .req1_a(d8_r1a), .req1_b(d8_r1b),
        .res_valid(d8_rv), .res_ready(d8_rr), .res_id(d8_rid),
        .res_sum(d8_rsum), .res_cout(d8_rcout), .busy(d8_busy)
    );

    serial_add_arbiter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(d4_r0v), .req0_ready(d4_r0r), .req0_a(d4_r0a), .req0_b(d4_r0b),
        .req1_valid(d4_r1v), .req1_ready(d4_r1r), .req1_a(d4_r1a), .req1_b(d4_r1b),
        .res_valid(d4_rv), .res_ready(d4_rr), .res_id(d4_rid),
        .res_sum(d4_rsum), .res_cout(d4_rcout), .busy(d4_busy)
    );

    function automatic res8_t model8(input logic id, input logic [7:0] a, input logic [7:0] b);
        res8_t e;
        e.id = id;
        {e.cout, e.sum} = {1'b0, a} + {1'b0, b};
        return e;
    endfunction

    // Drives one operation on the 8-bit instance with res_ready=1 and reports
    // the accept-to-valid latency plus the observed and expected results.
    task automatic do_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output res8_t got, output res8_t exp_r);
        bit seen;
        seen = 1'b0;
        lat = -1;
        got = 'x;
        exp_r = '0;
        @(posedge clk); #1;
        d8_rr = 1'b1;
        if (id) begin d8_r1v = 1'b1; d8_r1a = a; d8_r1b = b; end
        else    begin d8_r0v = 1'b1; d8_r0a = a; d8_r0b = b; end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if ((id ? d8_r1r : d8_r0r) === 1'b1) seen = 1'b1;
        end
        if (seen) begin
            sb8.push_back(model8(id, a, b));
            @(posedge clk); #1;
            d8_r0v = 1'b0;
            d8_r1v = 1'b0;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (d8_rv === 1'b1) begin
                    lat = i;
                    got = '{d8_rid, d8_rcout, d8_rsum};
                    break;
                end
            end
        end
        d8_r0v = 1'b0;
        d8_r1v = 1'b0;
        if (sb8.size() > 0) exp_r = sb8.pop_front();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        chk_cnt++;
        if ({d8_rv, d8_rid, d8_rsum, d8_rcout, d8_busy, d8_r0r, d8_r1r} !== 14'd0) $display("FAIL reset_d8 got %h want 0", {d8_rv, d8_rid, d8_rsum, d8_rcout, d8_busy, d8_r0r, d8_r1r});
        else pass_cnt++;
        chk_cnt++;
        if ({d4_rv, d4_rid, d4_rsum, d4_rcout, d4_busy, d4_r0r, d4_r1r} !== 10'd0) $display("FAIL reset_d4 got %h want 0", {d4_rv, d4_rid, d4_rsum, d4_rcout, d4_busy, d4_r0r, d4_r1r});
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({d8_rv, d8_busy, d8_r0r, d8_r1r} !== 4'd0) $display("FAIL reset_release got %b want 0000", {d8_rv, d8_busy, d8_r0r, d8_r1r});
        else pass_cnt++;
    endtask

    task automatic test_fairness();
        int nres, ovl;
        logic acc0, acc1;
        res8_t got, e;
        nres = 0;
        ovl = 0;
        @(posedge clk); #1;
        d8_rr = 1'b1;
        d8_r0v = 1'b1; d8_r0a = 8'($urandom); d8_r0b = 8'($urandom);
        d8_r1v = 1'b1; d8_r1a = 8'($urandom); d8_r1b = 8'($urandom);
        for (int cyc = 0; cyc < 120 && nres < 4; cyc++) begin
            @(negedge clk);
            if (d8_r0r === 1'b1 && d8_r1r === 1'b1) ovl++;
            acc0 = d8_r0r;
            acc1 = d8_r1r;
            if (acc0) sb8.push_back(model8(1'b0, d8_r0a, d8_r0b));
            if (acc1) sb8.push_back(model8(1'b1, d8_r1a, d8_r1b));
            if (d8_rv === 1'b1) begin
                got = '{d8_rid, d8_rcout, d8_rsum};
                e = (sb8.size() > 0) ? sb8.pop_front() : res8_t'('0);
                chk_cnt++;
                if (got !== e) $display("FAIL fair_result %0d got %h want %h", nres, got, e);
                else pass_cnt++;
                chk_cnt++;
                if (d8_rid !== 1'(nres % 2)) $display("FAIL fair_order %0d got id %b want %b", nres, d8_rid, 1'(nres % 2));
                else pass_cnt++;
                nres++;
            end
            @(posedge clk); #1;
            if (acc0) begin d8_r0a = 8'($urandom); d8_r0b = 8'($urandom); end
            if (acc1) begin d8_r1a = 8'($urandom); d8_r1b = 8'($urandom); end
        end
        d8_r0v = 1'b0;
        d8_r1v = 1'b0;
        chk_cnt++;
        if (nres != 4) $display("FAIL fair_count got %0d want 4", nres);
        else pass_cnt++;
        chk_cnt++;
        if (ovl != 0) $display("FAIL fair_overlap got %0d want 0", ovl);
        else pass_cnt++;
        sb8.delete();
    endtask

    task automatic test_basic();
        int lat;
        res8_t got, e;
        do_op(1'b0, 8'h5A, 8'h3C, lat, got, e);
        chk_cnt++;
        if (lat != 9) $display("FAIL basic_latency got %0d want 9", lat);
        else pass_cnt++;
        chk_cnt++;
        if (got !== e) $display("FAIL basic_result got %h want %h", got, e);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({d8_busy, d8_rv} !== 2'b00) $display("FAIL basic_idle got %b want 00", {d8_busy, d8_rv});
        else pass_cnt++;
    endtask

    task automatic test_carry();
        int lat;
        res8_t got, e;
        do_op(1'b1, 8'hFF, 8'h01, lat, got, e);
        chk_cnt++;
        if (got !== e) $display("FAIL carry_ff_01 got %h want %h", got, e);
        else pass_cnt++;
        do_op(1'b1, 8'hFF, 8'hFF, lat, got, e);
        chk_cnt++;
        if (got !== e) $display("FAIL carry_ff_ff got %h want %h", got, e);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        res8_t snap, e, got;
        int unstable;
        bit seen;
        unstable = 0;
        seen = 1'b0;
        @(posedge clk); #1;
        d8_rr = 1'b0;
        d8_r0v = 1'b1; d8_r0a = 8'h77; d8_r0b = 8'h99;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (d8_r0r === 1'b1) seen = 1'b1;
        end
        if (seen) sb8.push_back(model8(1'b0, 8'h77, 8'h99));
        @(posedge clk); #1;
        d8_r0v = 1'b0;
        d8_r1v = 1'b1; d8_r1a = 8'h11; d8_r1b = 8'h22;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (d8_rv === 1'b1) seen = 1'b1;
        end
        snap = '{d8_rid, d8_rcout, d8_rsum};
        e = (sb8.size() > 0) ? sb8.pop_front() : res8_t'('0);
        chk_cnt++;
        if (!seen || snap !== e) $display("FAIL bp_result got %h want %h", snap, e);
        else pass_cnt++;
        repeat (20) begin
            @(negedge clk);
            if ({d8_rv, d8_rid, d8_rcout, d8_rsum} !== {1'b1, snap} || d8_r0r !== 1'b0 || d8_r1r !== 1'b0) unstable++;
        end
        chk_cnt++;
        if (unstable != 0) $display("FAIL bp_stable got %0d unstable cycles want 0", unstable);
        else pass_cnt++;
        @(posedge clk); #1;
        d8_rr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({d8_rv, d8_r1r} !== 2'b01) $display("FAIL bp_take got %b want 01", {d8_rv, d8_r1r});
        else pass_cnt++;
        if (d8_r1r === 1'b1) sb8.push_back(model8(1'b1, 8'h11, 8'h22));
        @(posedge clk); #1;
        d8_r1v = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (d8_rv === 1'b1) seen = 1'b1;
        end
        got = '{d8_rid, d8_rcout, d8_rsum};
        e = (sb8.size() > 0) ? sb8.pop_front() : res8_t'('0);
        chk_cnt++;
        if (!seen || got !== e) $display("FAIL bp_pending got %h want %h", got, e);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat, spurious;
        res8_t got, e;
        bit seen;
        seen = 1'b0;
        spurious = 0;
        @(posedge clk); #1;
        d8_rr = 1'b1;
        d8_r0v = 1'b1; d8_r0a = 8'h12; d8_r0b = 8'h34;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (d8_r0r === 1'b1) seen = 1'b1;
        end
        if (seen) sb8.push_back(model8(1'b0, 8'h12, 8'h34));
        @(posedge clk); #1;
        d8_r0v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({d8_rv, d8_rid, d8_rsum, d8_rcout, d8_busy, d8_r0r, d8_r1r} !== 14'd0) $display("FAIL midrst_outputs got %h want 0", {d8_rv, d8_rid, d8_rsum, d8_rcout, d8_busy, d8_r0r, d8_r1r});
        else pass_cnt++;
        sb8.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (d8_rv !== 1'b0 || d8_busy !== 1'b0) spurious++;
        end
        chk_cnt++;
        if (spurious != 0) $display("FAIL midrst_quiet got %0d active cycles want 0", spurious);
        else pass_cnt++;
        do_op(1'b0, 8'h12, 8'h34, lat, got, e);
        chk_cnt++;
        if (got !== e || lat != 9) $display("FAIL midrst_retry got %h lat %0d want %h lat 9", got, lat, e);
        else pass_cnt++;
    endtask

    task automatic test_sweep4();
        int n0, n1, nres, cyc, ovl;
        bit started;
        logic acc0, acc1;
        logic [5:0] got, e;
        n0 = 0; n1 = 1; nres = 0; cyc = 0; ovl = 0;
        started = 1'b0;
        @(posedge clk); #1;
        d4_rr = 1'b1;
        d4_r0v = 1'b1; d4_r0a = 4'(n0 >> 4); d4_r0b = 4'(n0);
        d4_r1v = 1'b1; d4_r1a = 4'(n1 >> 4); d4_r1b = 4'(n1);
        for (int t = 0; t < 2000 && nres < 256; t++) begin
            @(negedge clk);
            if (d4_r0r === 1'b1 || d4_r1r === 1'b1) started = 1'b1;
            if (started) cyc++;
            if (d4_r0r === 1'b1 && d4_r1r === 1'b1) ovl++;
            acc0 = d4_r0r;
            acc1 = d4_r1r;
            if (acc0) sb4.push_back({1'b0, {1'b0, d4_r0a} + {1'b0, d4_r0b}});
            if (acc1) sb4.push_back({1'b1, {1'b0, d4_r1a} + {1'b0, d4_r1b}});
            if (d4_rv === 1'b1) begin
                got = {d4_rid, d4_rcout, d4_rsum};
                e = (sb4.size() > 0) ? sb4.pop_front() : 6'h3F;
                chk_cnt++;
                if (got !== e) $display("FAIL sweep_result %0d got %h want %h", nres, got, e);
                else pass_cnt++;
                nres++;
            end
            if (nres < 256) begin
                @(posedge clk); #1;
                if (acc0) begin
                    n0 += 2;
                    if (n0 > 255) d4_r0v = 1'b0;
                    else begin d4_r0a = 4'(n0 >> 4); d4_r0b = 4'(n0); end
                end
                if (acc1) begin
                    n1 += 2;
                    if (n1 > 255) d4_r1v = 1'b0;
                    else begin d4_r1a = 4'(n1 >> 4); d4_r1b = 4'(n1); end
                end
            end
        end
        d4_r0v = 1'b0;
        d4_r1v = 1'b0;
        chk_cnt++;
        if (nres != 256 || cyc != 256 * 6) $display("FAIL sweep_cycles got %0d results in %0d cycles want 256 in %0d", nres, cyc, 256 * 6);
        else pass_cnt++;
        chk_cnt++;
        if (ovl != 0) $display("FAIL sweep_overlap got %0d want 0", ovl);
        else pass_cnt++;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        test_fairness();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid();
        test_sweep4();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/serial_add_arbiter.md
Name: serial_add_arbiter

Overview:
- Controller that time-shares one bit-serial adder cell between two requesters. The cell is two half adders plus a carry flip-flop, i.e. one full-adder bit per cycle.
- Arbitrates between two operand ports using round-robin, loads the winner's operands and sequences WIDTH add cycles LSB-first.
- Returns sum and carry-out on a single result port with a valid/ready handshake.
- Sits between control-path clients and the shared adder resource. Replaces one WIDTH-bit parallel adder per client.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has operands.
- req0_ready  output  1  requester 0 operands accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req1_valid  input  1  requester 1 has operands.
- req1_ready  output  1  requester 1 operands accepted this cycle.
- req1_a  input  WIDTH  requester 1 operand A.
- req1_b  input  WIDTH  requester 1 operand B.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes result.
- res_id  output  1  requester that owns the result (0/1).
- res_sum  output  WIDTH  a+b mod 2^WIDTH.
- res_cout  output  1  carry out of MSB.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - All outputs 0; FSM in IDLE.
  - Operand, sum and carry registers 0; bit counter 0.
  - last_served = 1, so requester 0 wins the first tie.
- FSM states: IDLE, RUN, DONE.
- Grant, IDLE only, combinational:
  - Only one reqN_valid high: grant that requester.
  - Both high: grant the requester != last_served.
  - reqN_ready = (state==IDLE) & grant==N. Never both high. Both are 0 outside IDLE.
- Accept edge (valid & ready):
  - Load A/B shift registers from the winner; carry=0, counter=0.
  - res_id = winner; last_served = winner.
  - State -> RUN.
- RUN, each edge:
  - s = A[0]^B[0]^c; c' = (A[0]&B[0]) | (c&(A[0]^B[0])).
  - Shift A, B right by 1; shift s into sum MSB, sum shifts right; c = c'; counter++.
  - On the edge where counter==WIDTH-1: res_cout = c', res_valid = 1, state -> DONE.
- Latency: res_valid rises exactly WIDTH+1 cycles after the accept cycle (accept edge + WIDTH bit edges).
- DONE:
  - res_valid=1; res_sum, res_cout, res_id held stable while res_ready=0 (backpressure of unbounded length).
  - res_valid & res_ready -> IDLE, res_valid=0.
  - Result registers keep their value until the next accept. Consumers sample them only with res_valid.
- Throughput: at most one operation per WIDTH+2 cycles. No new accept in the DONE-exit cycle.
- Requester holding:
  - Ungranted requesters keep valid/operands until ready; the block never drops a pending request.
  - Operand changes while not granted are legal; the value sampled is the one at the accept edge.
- Fairness: requester 1 continuously valid is served at most one operation after requester 0, and vice versa.
- Simultaneous events:
  - res_ready asserted while in RUN: ignored.
  - Requests arriving during RUN/DONE: wait; arbitration uses last_served at the IDLE cycle.
- Reset mid-operation (any state): immediate return to reset values.
  - In-flight operation discarded; no partial result emitted; last_served returns to 1.
- busy = (state != IDLE).

Test Plan:
- WIDTH=8, req0 only, a=0x5A, b=0x3C, res_ready=1:
  - req0_ready high 1 cycle; res_valid 9 cycles later.
  - res_sum=0x96, res_cout=0, res_id=0; back to IDLE the next cycle.
- Carry chain, req1 only, a=0xFF, b=0x01 -> res_sum=0x00, res_cout=1, res_id=1. Then a=0xFF, b=0xFF -> res_sum=0xFE, res_cout=1.
- Both valid continuously after reset: grants alternate 0,1,0,1.
  - res_id sequence 0,1,0,1; req0_ready and req1_ready never high together.
- Backpressure: res_ready=0 for 20 cycles after res_valid.
  - res_valid, res_sum, res_cout, res_id stable throughout; both reqN_ready stay 0.
  - Consumer takes the result on the first res_ready=1 cycle.
- Reset mid-RUN: assert rst_n=0 at bit 3 of a 0x12+0x34 add.
  - All outputs 0 immediately and busy=0; no res_valid afterwards.
  - Next request 0x12+0x34 gives 0x46, cout=0.
- Exhaustive WIDTH=4 sweep of all 256 a/b pairs via alternating requesters: every res_sum/res_cout matches a+b; total cycles = 256×(WIDTH+2).
